// File: rtl/gb_apu_pkg.sv
// gb_apu_pkg
// Shared types and constants for the Game Boy APU frame sequencer.
// The step masks hold one bit per sequencer step (bit n = step n) so the
// decode in the sequencer is a plain table lookup with no literals.
package gb_apu_pkg;

    typedef logic [2:0] frame_step_t;

    localparam frame_step_t STEP_FIRST = 3'd0;
    localparam frame_step_t STEP_INC   = 3'd1;

    // Length counters run at 256 Hz (steps 0,2,4,6), sweep at 128 Hz (2,6),
    // envelopes at 64 Hz (7).
    localparam logic [7:0]  LENGTH_STEPS = 8'b0101_0101;
    localparam logic [7:0]  SWEEP_STEPS  = 8'b0100_0100;
    localparam frame_step_t ENV_STEP     = 3'd7;

    // DIV bit whose falling edge drives the sequencer (normal / double speed).
    localparam int unsigned TICK_BIT    = 4;
    localparam int unsigned TICK_BIT_DS = 5;

endpackage

// File: rtl/gb_apu_falling_edge_detect.sv
// gb_apu_falling_edge_detect
// Registers the input every cycle and flags a 1->0 transition.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset, clears the history register
//   in    - monitored signal
//   fall  - combinational, high when previous sample was 1 and in is 0
module gb_apu_falling_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic fall
);

    logic in_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign fall = in_q & ~in;

endmodule

// File: rtl/gb_apu_frame_sequencer.sv
// gb_apu_frame_sequencer
// 512 Hz frame sequencer of the Game Boy APU. Each falling edge of the
// selected DIV bit executes one of eight steps and emits registered
// one-cycle clock pulses to the length, sweep and envelope units.
//
// Step table:
//   step | action
//   0    | length
//   1    | none
//   2    | length + sweep
//   3    | none
//   4    | length
//   5    | none
//   6    | length + sweep
//   7    | envelope
//
// Ports:
//   clk              - system clock, rising edge
//   reset            - synchronous active-high reset
//   apu_enable       - NR52 bit 7; low holds the sequencer at step 0
//   div              - DIV register upper byte
//   double_speed     - (only with GB_APU_DOUBLE_SPEED_EN) tick from div[5]
//   clk_length_ctr   - one-cycle pulse to all length counters
//   clk_sweep        - one-cycle pulse to the channel-1 sweep
//   clk_vol_env      - one-cycle pulse to all envelope units
//   step             - index of the next step to execute
//   length_skip_next - high when the next step does not clock length
//
// Build option: define GB_APU_DOUBLE_SPEED_EN to add the double_speed input.
module gb_apu_frame_sequencer
    import gb_apu_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 apu_enable,
    input  logic [DIV_WIDTH-1:0] div,
`ifdef GB_APU_DOUBLE_SPEED_EN
    input  logic                 double_speed,
`endif
    output logic                 clk_length_ctr,
    output logic                 clk_sweep,
    output logic                 clk_vol_env,
    output logic [2:0]           step,
    output logic                 length_skip_next
);

    logic        tick_src;
    logic        tick;
    logic        unused_div;

    frame_step_t step_q, step_d;
    logic        len_q, len_d;
    logic        sweep_q, sweep_d;
    logic        env_q, env_d;

    // Only one or two DIV bits matter; fold the rest into a sink.
    assign unused_div = ^div;

`ifdef GB_APU_DOUBLE_SPEED_EN
    // Switching double_speed can itself create a 1->0 on the selected bit;
    // the hardware counts that as a tick, so no masking is done here.
    assign tick_src = double_speed ? div[TICK_BIT_DS] : div[TICK_BIT];
`else
    assign tick_src = div[TICK_BIT];
`endif

    // The edge history keeps updating while the APU is off so that enabling
    // never sees a stale edge.
    gb_apu_falling_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .in    (tick_src),
        .fall  (tick)
    );

    always_comb begin
        step_d  = step_q;
        len_d   = 1'b0;
        sweep_d = 1'b0;
        env_d   = 1'b0;
        if (!apu_enable) begin
            step_d = STEP_FIRST;
        end else if (tick) begin
            len_d   = LENGTH_STEPS[step_q];
            sweep_d = SWEEP_STEPS[step_q];
            env_d   = (step_q == ENV_STEP);
            step_d  = step_q + STEP_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q  <= STEP_FIRST;
            len_q   <= 1'b0;
            sweep_q <= 1'b0;
            env_q   <= 1'b0;
        end else begin
            step_q  <= step_d;
            len_q   <= len_d;
            sweep_q <= sweep_d;
            env_q   <= env_d;
        end
    end

    assign clk_length_ctr   = len_q;
    assign clk_sweep        = sweep_q;
    assign clk_vol_env      = env_q;
    assign step             = step_q;
    assign length_skip_next = step_q[0];

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// tb_gb_apu_frame_sequencer
// Directed and random stimulus for gb_apu_frame_sequencer, checked every
// cycle against a step-count model of the frame sequencer.
// Build option: GB_APU_DOUBLE_SPEED_EN adds the double_speed scenario.
module tb_gb_apu_frame_sequencer;

    localparam int DIV_WIDTH = 8;

    logic                 clk;
    logic                 reset;
    logic                 apu_enable;
    logic [DIV_WIDTH-1:0] div;
`ifdef GB_APU_DOUBLE_SPEED_EN
    logic                 double_speed;
`endif
    logic                 clk_length_ctr;
    logic                 clk_sweep;
    logic                 clk_vol_env;
    logic [2:0]           step;
    logic                 length_skip_next;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: number of the next step, previous sample of the
    // selected DIV bit, and the pulses expected after the current edge.
    int m_step = 0;
    bit m_prev = 1'b0;
    bit m_len  = 1'b0;
    bit m_swp  = 1'b0;
    bit m_env  = 1'b0;

    int cnt_len = 0;
    int cnt_swp = 0;
    int cnt_env = 0;

    gb_apu_frame_sequencer #(.DIV_WIDTH(DIV_WIDTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .apu_enable       (apu_enable),
        .div              (div),
`ifdef GB_APU_DOUBLE_SPEED_EN
        .double_speed     (double_speed),
`endif
        .clk_length_ctr   (clk_length_ctr),
        .clk_sweep        (clk_sweep),
        .clk_vol_env      (clk_vol_env),
        .step             (step),
        .length_skip_next (length_skip_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input bit r, input bit e, input bit sel);
        logic [DIV_WIDTH-1:0] d;
        bit tick;
        d = DIV_WIDTH'($urandom);
`ifdef GB_APU_DOUBLE_SPEED_EN
        if (double_speed) d[5] = sel;
        else              d[4] = sel;
`else
        d[4] = sel;
`endif
        reset      = r;
        apu_enable = e;
        div        = d;
        @(posedge clk);
        #1;
        tick = m_prev && !sel;
        m_len = 1'b0;
        m_swp = 1'b0;
        m_env = 1'b0;
        if (r) begin
            m_step = 0;
            m_prev = 1'b0;
        end else begin
            m_prev = sel;
            if (!e) begin
                m_step = 0;
            end else if (tick) begin
                m_len  = (m_step % 2 == 0);
                m_swp  = (m_step % 4 == 2);
                m_env  = (m_step == 7);
                m_step = (m_step + 1) % 8;
            end
        end
        check("step", 8'(step), 8'(m_step));
        check("clk_length_ctr", 8'(clk_length_ctr), 8'(m_len));
        check("clk_sweep", 8'(clk_sweep), 8'(m_swp));
        check("clk_vol_env", 8'(clk_vol_env), 8'(m_env));
        check("length_skip_next", 8'(length_skip_next), 8'(m_step % 2));
        cnt_len += int'(clk_length_ctr);
        cnt_swp += int'(clk_sweep);
        cnt_env += int'(clk_vol_env);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            cycle(1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic clear_counts;
        cnt_len = 0;
        cnt_swp = 0;
        cnt_env = 0;
    endtask

    initial begin
        reset      = 1'b1;
        apu_enable = 1'b0;
        div        = '0;
`ifdef GB_APU_DOUBLE_SPEED_EN
        double_speed = 1'b0;
`endif

        // Reset state
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        check("reset_step", 8'(step), 8'd0);
        check("reset_pulses", 8'({clk_length_ctr, clk_sweep, clk_vol_env}), 8'd0);

        // Eight ticks: full pattern and wrap
        cycle(1'b0, 1'b1, 1'b0);
        clear_counts();
        tick_n(8);
        check("8tick_len_cnt", 8'(cnt_len), 8'd4);
        check("8tick_swp_cnt", 8'(cnt_swp), 8'd2);
        check("8tick_env_cnt", 8'(cnt_env), 8'd1);
        check("8tick_wrap", 8'(step), 8'd0);

        // Sixteen ticks
        clear_counts();
        tick_n(16);
        check("16tick_len_cnt", 8'(cnt_len), 8'd8);
        check("16tick_swp_cnt", 8'(cnt_swp), 8'd4);
        check("16tick_env_cnt", 8'(cnt_env), 8'd2);

        // Disable at step 5, toggle while off, re-enable
        tick_n(5);
        check("at_step5", 8'(step), 8'd5);
        clear_counts();
        cycle(1'b0, 1'b0, 1'b1);
        repeat (3) begin
            cycle(1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0);
        end
        check("off_pulses", 8'(cnt_len + cnt_swp + cnt_env), 8'd0);
        check("off_step", 8'(step), 8'd0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        check("reenable_len", 8'(clk_length_ctr), 8'd1);
        check("reenable_step", 8'(step), 8'd1);
        cycle(1'b0, 1'b1, 1'b0);

        // Tick coincident with enable falling at step 2
        tick_n(1);
        check("at_step2", 8'(step), 8'd2);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("coinc_pulses", 8'({clk_length_ctr, clk_sweep, clk_vol_env}), 8'd0);
        check("coinc_step", 8'(step), 8'd0);

        // Reset in the tick cycle at step 7
        cycle(1'b0, 1'b1, 1'b0);
        tick_n(7);
        check("at_step7", 8'(step), 8'd7);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        check("rst_tick_env", 8'(clk_vol_env), 8'd0);
        check("rst_tick_step", 8'(step), 8'd0);

        // Release reset with the tick bit high; first fall is a tick
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        check("post_rst_len", 8'(clk_length_ctr), 8'd1);
        check("post_rst_step", 8'(step), 8'd1);

`ifdef GB_APU_DOUBLE_SPEED_EN
        // Double speed: div[4] toggles randomly but only div[5] ticks
        double_speed = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        clear_counts();
        repeat (20) cycle(1'b0, 1'b1, 1'b1);
        check("ds_no_tick", 8'(cnt_len + cnt_swp + cnt_env), 8'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check("ds_tick_len", 8'(clk_length_ctr), 8'd1);
        check("ds_tick_step", 8'(step), 8'd1);
        tick_n(3);
        double_speed = 1'b0;
        cycle(1'b0, 1'b1, 1'b0);
`endif

        // Random traffic
        repeat (400) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
